popcount_acc_ctrl: RTL and testbench

POPCOUNT_ACC_CTRL -- requirements
Module: popcount_acc_ctrl

---
 rtl/popcount_acc_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_popcount_acc_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_acc_ctrl.sv
// Job controller that streams num_words 64-bit words through a pipelined popcount and accumulates the total.
// Optional POPCOUNT_ACC_MAXPOP_EN adds max_pop, the largest per-word count of the job.

module popcount64 #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [63:0] d,
    output logic [6:0]  q
);
    logic [6:0] cnt;

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            cnt = cnt + 7'(d[i]);
        end
    end

    generate
        if (LATENCY == 0) begin : g_comb
            assign q = cnt;
        end else begin : g_reg
            logic [6:0] stage [LATENCY];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < LATENCY; i++) begin
                        stage[i] <= '0;
                    end
                end else if (en) begin
                    stage[0] <= cnt;
                    for (int unsigned i = 1; i < LATENCY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign q = stage[LATENCY-1];
        end
    endgenerate
endmodule

module popcount_acc_ctrl #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned SUM_W  = CNT_W + 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    output logic             done,
    output logic [SUM_W-1:0] sum
`ifdef POPCOUNT_ACC_MAXPOP_EN
    ,
    output logic [6:0]       max_pop
`endif
);
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    localparam logic [1:0] DRAIN_LAST = (LATENCY > 0) ? 2'(LATENCY - 1) : 2'd0;

    state_t           state, state_next;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       drain_cnt;
    logic [6:0]       word_pop;
    logic             xfer;
    logic             last_word;
    logic             start_acc;
    logic             acc_valid;

    popcount64 #(.LATENCY(LATENCY)) u_pop (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .d     (in_data),
        .q     (word_pop)
    );

    assign start_acc = (state == IDLE) && start;
    assign xfer      = in_valid && in_ready;
    assign last_word = xfer && (remaining == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        in_ready   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_words == '0) ? DONE : FEED;
                end
            end
            FEED: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (last_word) begin
                    state_next = (LATENCY == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // acc_valid marks the cycle in which word_pop belongs to a transferred word.
    generate
        if (LATENCY == 0) begin : g_nopipe
            assign acc_valid = xfer;
        end else begin : g_pipe
            logic [LATENCY-1:0] vpipe;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vpipe <= '0;
                end else begin
                    vpipe[0] <= xfer;
                    for (int unsigned i = 1; i < LATENCY; i++) begin
                        vpipe[i] <= vpipe[i-1];
                    end
                end
            end

            assign acc_valid = vpipe[LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            drain_cnt <= '0;
            sum       <= '0;
        end else begin
            if (start_acc) begin
                remaining <= num_words;
            end else if (xfer) begin
                remaining <= remaining - CNT_W'(1);
            end

            if (last_word) begin
                drain_cnt <= DRAIN_LAST;
            end else if ((state == DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - 2'd1;
            end

            if (start_acc) begin
                sum <= '0;
            end else if (acc_valid) begin
                sum <= sum + SUM_W'(word_pop);
            end
        end
    end

`ifdef POPCOUNT_ACC_MAXPOP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_pop <= '0;
        end else if (start_acc) begin
            max_pop <= '0;
        end else if (acc_valid && (word_pop > max_pop)) begin
            max_pop <= word_pop;
        end
    end
`endif
endmodule

// File: tb/tb_popcount_acc_ctrl.sv
// Directed bench for popcount_acc_ctrl: table-driven jobs plus reset-in-DRAIN sequence.
// Extra instances at LATENCY 0, 1 and 3 watch the first job for done timing.

module tb_popcount_acc_ctrl;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned SUM_W = CNT_W + 7;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             start     = 1'b0;
    logic [CNT_W-1:0] num_words = '0;
    logic             in_valid  = 1'b0;
    logic [63:0]      in_data   = '0;
    logic             busy, in_ready, done;
    logic [SUM_W-1:0] sum;
`ifdef POPCOUNT_ACC_MAXPOP_EN
    logic [6:0]       max_pop;
    logic [6:0]       aux_max [3];
`endif
    logic [2:0]       aux_busy, aux_ready, aux_done;
    logic [SUM_W-1:0] aux_sum [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    popcount_acc_ctrl #(.LATENCY(2), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_words (num_words),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .done      (done),
        .sum       (sum)
`ifdef POPCOUNT_ACC_MAXPOP_EN
        ,
        .max_pop   (max_pop)
`endif
    );

    generate
        for (genvar g = 0; g < 3; g++) begin : g_aux
            popcount_acc_ctrl #(.LATENCY((g == 0) ? 0 : ((g == 1) ? 1 : 3)), .CNT_W(CNT_W)) u_aux (
                .clk       (clk),
                .rst_n     (rst_n),
                .start     (start),
                .num_words (num_words),
                .busy      (aux_busy[g]),
                .in_valid  (in_valid),
                .in_ready  (aux_ready[g]),
                .in_data   (in_data),
                .done      (aux_done[g]),
                .sum       (aux_sum[g])
`ifdef POPCOUNT_ACC_MAXPOP_EN
                ,
                .max_pop   (aux_max[g])
`endif
            );
        end
    endgenerate

    typedef struct {
        string            name;
        int               n;
        logic [3:0][63:0] words;
        int               gap;
        bit               mid_start;
        int               exp_sum;
        int               exp_delta;
        int               exp_max;
    } vec_t;

    function automatic vec_t mk(input string nm, input int n, input logic [63:0] w0,
                                input logic [63:0] w1, input logic [63:0] w2, input logic [63:0] w3,
                                input int gap, input bit ms, input int es, input int ed, input int em);
        vec_t v;
        v.name      = nm;
        v.n         = n;
        v.words[0]  = w0;
        v.words[1]  = w1;
        v.words[2]  = w2;
        v.words[3]  = w3;
        v.gap       = gap;
        v.mid_start = ms;
        v.exp_sum   = es;
        v.exp_delta = ed;
        v.exp_max   = em;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input vec_t v, input bit check_aux);
        int cyc, last_t, done_cyc, k, gapcnt;
        bit seen_ready, pulsed;
        int aux_cyc [3];
        int aux_exp [3];
        aux_exp = '{1, 2, 4};
        aux_cyc = '{-1, -1, -1};
        start     = 1'b1;
        num_words = CNT_W'(v.n);
        step();
        start = 1'b0;
        chk({v.name, " busy_after_start"}, 64'(busy), 64'(1));
        cyc = 1; last_t = 0; done_cyc = -1; k = 0; gapcnt = 0;
        seen_ready = 1'b0; pulsed = 1'b0;
        while (done_cyc < 0 && cyc < 200) begin
            for (int i = 0; i < 3; i++) begin
                if (aux_done[i] && aux_cyc[i] < 0) aux_cyc[i] = cyc;
            end
            if (done) begin
                done_cyc = cyc;
                chk({v.name, " sum"}, 64'(sum), 64'(v.exp_sum));
`ifdef POPCOUNT_ACC_MAXPOP_EN
                chk({v.name, " max_pop"}, 64'(max_pop), 64'(v.exp_max));
`endif
            end else begin
                if (in_ready) seen_ready = 1'b1;
                start = 1'b0;
                if (v.mid_start && k == 1 && !pulsed) begin
                    start     = 1'b1;
                    num_words = CNT_W'(9);
                    pulsed    = 1'b1;
                end
                in_valid = (k < v.n) && (gapcnt == 0);
                in_data  = in_valid ? v.words[k] : '0;
                if (in_valid && in_ready) begin
                    k++;
                    last_t = cyc;
                    gapcnt = v.gap;
                end else if (!in_valid && gapcnt > 0) begin
                    gapcnt--;
                end
                step();
                cyc++;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (done_cyc < 0) begin
            tests++;
            fails++;
            $display("FAIL %s done_timeout: got no done within 200 cycles, expected done", v.name);
        end else begin
            chk({v.name, " done_delay"}, 64'(done_cyc - last_t), 64'(v.exp_delta));
        end
        chk({v.name, " in_ready_seen"}, 64'(seen_ready), 64'(v.n > 0));
        for (int p = 0; p < 4; p++) begin
            step();
            cyc++;
            if (p == 0) begin
                chk({v.name, " busy_after_done"}, 64'(busy), 64'(0));
                chk({v.name, " done_one_cycle"}, 64'(done), 64'(0));
            end
            for (int i = 0; i < 3; i++) begin
                if (aux_done[i] && aux_cyc[i] < 0) aux_cyc[i] = cyc;
            end
        end
        chk({v.name, " sum_holds"}, 64'(sum), 64'(v.exp_sum));
        if (check_aux) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("%s aux%0d_done_delay", v.name, i), 64'(aux_cyc[i] - last_t), 64'(aux_exp[i]));
                chk($sformatf("%s aux%0d_sum", v.name, i), 64'(aux_sum[i]), 64'(v.exp_sum));
            end
        end
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = mk("allones4", 4, '1, '1, '1, '1, 0, 1'b0, 256, 3, 64);
        vecs[1] = mk("zero_words", 0, '0, '0, '0, '0, 0, 1'b0, 0, 1, 0);
        vecs[2] = mk("gaps", 3, 64'h1, 64'h3, 64'hFFFF_0000_0000_0000, '0, 2, 1'b0, 19, 3, 16);
        vecs[3] = mk("mixed", 4, 64'hFF, 64'h5555_5555_5555_5555, 64'h7, 64'h1000, 0, 1'b0, 44, 3, 32);
        vecs[4] = mk("gap1", 2, 64'hF0F0, 64'h8000_0000_0000_0001, '0, '0, 1, 1'b0, 10, 3, 8);
        vecs[5] = mk("mid_start", 3, 64'h1, 64'h3, 64'hFFFF_0000_0000_0000, '0, 2, 1'b1, 19, 3, 16);
        vecs[6] = mk("zero_data", 1, '0, '0, '0, '0, 0, 1'b0, 0, 3, 0);

        #12;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset in_ready", 64'(in_ready), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset sum", 64'(sum), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i], i == 0);
            step();
        end

        // Reset lands in the first DRAIN cycle, after one word has already been summed.
        start     = 1'b1;
        num_words = CNT_W'(3);
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = '1;
        step();
        step();
        step();
        in_valid = 1'b0;
        chk("drain busy_before_reset", 64'(busy), 64'(1));
        chk("drain in_ready", 64'(in_ready), 64'(0));
        chk("drain partial_sum", 64'(sum), 64'(64));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset busy", 64'(busy), 64'(0));
        chk("async_reset done", 64'(done), 64'(0));
        chk("async_reset sum", 64'(sum), 64'(0));
        step();
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("post_reset sum", 64'(sum), 64'(0));
        chk("post_reset busy", 64'(busy), 64'(0));
        run_job(mk("after_reset", 1, 64'hF0, '0, '0, '0, 0, 1'b0, 4, 3, 4), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
